serial_adder_host: RTL and testbench
====================================

Name: serial_adder_host

Overview:
- Initiator end of the 2-operand serial-add link.
- Takes parallel operands from a local requester and serialises them MSB-first onto the link.
- Waits for the responder's enable pulse, then deserialises the RES_W-bit result MSB-first.
- Returns the result in parallel, with a self-check flag and timeout detection.
- Used as the bench/system-side driver for the serial adder responder.

Parameters:
- OP_W, 2: operand width in bits. Must match the responder. RES_W = OP_W+1 is derived, not overridable.
- TIMEOUT, 8: maximum sampled edges in WAIT without ser_en_i before abort. Also the post-reset flush length.
- GAP_CYCLES, 1: idle cycles enforced after done/timeout before the next start is accepted. 0 is allowed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  OP_W  operand A; latched when start is accepted
- op_b  input  OP_W  operand B; latched when start is accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result valid in that cycle and held until the next accepted start
- result  output  RES_W  captured sum
- mismatch  output  1  valid with done; result != op_a+op_b (RES_W-bit compare of latched operands)
- timeout_err  output  1  one-cycle pulse on WAIT abort
- ser_en_o  output  1  link enable to responder
- ser_a_o  output  1  serial operand A bit
- ser_b_o  output  1  serial operand B bit
- ser_en_i  input  1  responder result-enable pulse
- ser_out_i  input  1  responder serial result bit (idles high)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, result=0, state=FLUSH.
- All outputs are registered.
- FLUSH: entered on reset release. busy=1; ser_* outputs held 0; ser_en_i ignored. Lasts TIMEOUT cycles, then IDLE. This lets an unreset responder drain.
- IDLE: busy=0.
  - On start=1 at edge S: latch op_a/op_b, clear mismatch, go to SEND.
  - From edge S drive ser_en_o=1, ser_a_o=op_a[OP_W-1], ser_b_o=op_b[OP_W-1].
- SEND: one bit per cycle, MSB first, OP_W cycles total.
  - ser_en_o is high only in the first (MSB) cycle.
  - After the LSB cycle (edge S+OP_W), drive ser_* to 0 and enter WAIT.
  - For OP_W=2: responder samples the MSB at S+1 and the LSB at S+2.
- WAIT: count sampled edges.
  - At the first edge with ser_en_i=1, capture ser_out_i as result[RES_W-1] and go to RECV.
  - Nominal (OP_W=2): ser_en_i seen at S+4.
  - If TIMEOUT edges pass without ser_en_i: pulse timeout_err, leave result unchanged, go to GAP.
- RECV: capture the remaining RES_W-1 bits on consecutive edges, MSB to LSB. ser_en_i is ignored here; it must be low but is not checked.
  - At the last capture edge (S+6 nominal), go to GAP with done=1 the following cycle.
  - mismatch is valid in the same cycle as done.
- GAP: busy=1 for GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, go straight to IDLE.
  - Guarantees the responder has returned to idle before the next enable; its idle point is S+7 nominal.
- start while busy: ignored, never queued.
- ser_en_i in IDLE, GAP or FLUSH: ignored.
- Reset mid-transaction: outputs cleared immediately; FLUSH re-entered; no done or timeout_err is emitted.
- Arithmetic: expected sum = zero-extended op_a + op_b in RES_W bits. No overflow is possible.

Test Plan:
- Reset release, start=1 with op_a=3, op_b=3 at the first IDLE edge: ser_en_o high one cycle with a=1, b=1, then a=1, b=1. Responder returns bits 1,1,0. done at S+6+1 with result=3'b110, mismatch=0, busy low after GAP.
- op_a=2, op_b=1, then back-to-back op_a=0, op_b=0 with start held high: second start accepted on the first IDLE edge. Results 3'b011 then 3'b000. ser_en_o never asserted during the responder's output phase.
- Responder model stays silent after SEND: timeout_err pulses exactly TIMEOUT edges after WAIT entry. done never asserts; result keeps its previous value; IDLE reached after GAP.
- Responder model returns the wrong LSB (op 1+1 returns 3'b011): done with result=3'b011, mismatch=1.
- rst_n dropped during RECV: all outputs 0 asynchronously. busy=1 for TIMEOUT cycles after release. start during FLUSH ignored; accepted in IDLE.
- Spurious ser_en_i pulse in IDLE and during GAP: no state change, no done, no capture.

Source files
------------

// File: rtl/serial_adder_host_if.sv
// Bundle of the requester-side and link-side signals of the serial-add host.
// The slave modport is the host itself; the master modport is whatever
// drives requests and plays the responder.
interface serial_adder_host_if #(
    parameter int OP_W = 2
);
    localparam int RES_W = OP_W + 1;

    logic             start;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             mismatch;
    logic             timeout_err;
    logic             ser_en_o;
    logic             ser_a_o;
    logic             ser_b_o;
    logic             ser_en_i;
    logic             ser_out_i;

    modport master (
        output start, op_a, op_b, ser_en_i, ser_out_i,
        input  busy, done, result, mismatch, timeout_err,
               ser_en_o, ser_a_o, ser_b_o
    );

    modport slave (
        input  start, op_a, op_b, ser_en_i, ser_out_i,
        output busy, done, result, mismatch, timeout_err,
               ser_en_o, ser_a_o, ser_b_o
    );
endinterface

// File: rtl/serial_adder_host.sv
// Initiator end of the two-operand serial-add link. Serialises the latched
// operands MSB-first, waits for the responder's enable pulse, deserialises
// the OP_W+1 bit sum MSB-first and reports it with a self-check flag.
// Every output comes straight from a flop.
module serial_adder_host #(
    parameter int OP_W       = 2,
    parameter int TIMEOUT    = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_host_if.slave bus
);
    localparam int RES_W   = OP_W + 1;
    localparam int MAX_A   = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_MAX = (MAX_A > RES_W) ? MAX_A : RES_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts; the counter restarts at 0 on every state change.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SEND_LAST    = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] RECV_LAST    = CNT_W'(RES_W - 2);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } state_t;

    // With no gap requested a finished or aborted transfer returns to IDLE directly.
    localparam state_t AFTER_XFER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [OP_W-1:0]  op_a_reg, op_a_next;
    logic [OP_W-1:0]  op_b_reg, op_b_next;
    logic [OP_W-1:0]  sh_a_reg, sh_a_next;
    logic [OP_W-1:0]  sh_b_reg, sh_b_next;
    logic [RES_W-1:0] rx_reg, rx_next;
    logic [RES_W-1:0] result_reg, result_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             mismatch_reg, mismatch_next;
    logic             timeout_reg, timeout_next;
    logic             ser_en_reg, ser_en_next;
    logic             ser_a_reg, ser_a_next;
    logic             ser_b_reg, ser_b_next;

    logic [RES_W-1:0] rx_word;
    logic [RES_W-1:0] sum_exp;

    // Word formed by shifting in the bit arriving on this edge.
    assign rx_word = {rx_reg[RES_W-2:0], bus.ser_out_i};
    // Reference sum of the latched operands for the self-check flag.
    assign sum_exp = RES_W'(op_a_reg) + RES_W'(op_b_reg);

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_FLUSH;
            cnt_reg      <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            sh_a_reg     <= '0;
            sh_b_reg     <= '0;
            rx_reg       <= '0;
            result_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            mismatch_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            ser_en_reg   <= 1'b0;
            ser_a_reg    <= 1'b0;
            ser_b_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            sh_a_reg     <= sh_a_next;
            sh_b_reg     <= sh_b_next;
            rx_reg       <= rx_next;
            result_reg   <= result_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            mismatch_reg <= mismatch_next;
            timeout_reg  <= timeout_next;
            ser_en_reg   <= ser_en_next;
            ser_a_reg    <= ser_a_next;
            ser_b_reg    <= ser_b_next;
        end
    end

    // Next-state and phase counter; ser_en_i only matters while in WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FLUSH: if (cnt_reg == TIMEOUT_LAST) state_next = ST_IDLE;
            ST_IDLE:  if (bus.start) state_next = ST_SEND;
            ST_SEND:  if (cnt_reg == SEND_LAST) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.ser_en_i)                   state_next = ST_RECV;
                else if (cnt_reg == TIMEOUT_LAST)   state_next = AFTER_XFER;
            end
            ST_RECV:  if (cnt_reg == RECV_LAST) state_next = AFTER_XFER;
            ST_GAP:   if (cnt_reg == GAP_LAST) state_next = ST_IDLE;
            default:  state_next = ST_FLUSH;
        endcase

        if ((state_next != state_reg) || (state_reg == ST_IDLE))
            cnt_next = '0;
        else
            cnt_next = cnt_reg + CNT_W'(1);
    end

    // Next values of the registered outputs and operand/result datapath.
    always_comb begin
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        sh_a_next     = sh_a_reg;
        sh_b_next     = sh_b_reg;
        rx_next       = rx_reg;
        result_next   = result_reg;
        mismatch_next = mismatch_reg;
        done_next     = 1'b0;
        timeout_next  = 1'b0;
        ser_en_next   = 1'b0;
        ser_a_next    = 1'b0;
        ser_b_next    = 1'b0;
        busy_next     = (state_next != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    op_a_next     = bus.op_a;
                    op_b_next     = bus.op_b;
                    mismatch_next = 1'b0;
                    // MSB goes out with the enable on the accepting edge.
                    ser_en_next   = 1'b1;
                    ser_a_next    = bus.op_a[OP_W-1];
                    ser_b_next    = bus.op_b[OP_W-1];
                    sh_a_next     = bus.op_a << 1;
                    sh_b_next     = bus.op_b << 1;
                end
            end
            ST_SEND: begin
                // Remaining bits follow without enable; link returns to 0 after the LSB.
                if (cnt_reg != SEND_LAST) begin
                    ser_a_next = sh_a_reg[OP_W-1];
                    ser_b_next = sh_b_reg[OP_W-1];
                    sh_a_next  = sh_a_reg << 1;
                    sh_b_next  = sh_b_reg << 1;
                end
            end
            ST_WAIT: begin
                if (bus.ser_en_i)
                    rx_next = {{(RES_W-1){1'b0}}, bus.ser_out_i};
                else if (cnt_reg == TIMEOUT_LAST)
                    timeout_next = 1'b1;
            end
            ST_RECV: begin
                rx_next = rx_word;
                // Result is only published once complete, so an abort leaves it intact.
                if (cnt_reg == RECV_LAST) begin
                    result_next   = rx_word;
                    done_next     = 1'b1;
                    mismatch_next = (rx_word != sum_exp);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.result      = result_reg;
    assign bus.mismatch    = mismatch_reg;
    assign bus.timeout_err = timeout_reg;
    assign bus.ser_en_o    = ser_en_reg;
    assign bus.ser_a_o     = ser_a_reg;
    assign bus.ser_b_o     = ser_b_reg;
endmodule

// File: tb/tb_serial_adder_host.sv
// Self-checking bench for serial_adder_host: the bench acts as requester and
// as the serial-add responder, driven from a table of directed vectors plus
// hand-written reset and spurious-enable sequences.
module tb_serial_adder_host;
    localparam int OP_W       = 2;
    localparam int RES_W      = OP_W + 1;
    localparam int TIMEOUT    = 8;
    localparam int GAP_CYCLES = 1;

    // mode: 0 = well-behaved responder, 1 = silent responder, 2 = corrupt LSB
    typedef struct {
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        int               mode;
        logic             keep_start;
        logic             spur;
        logic [RES_W-1:0] exp_result;
        logic             exp_mismatch;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [7];

    serial_adder_host_if #(.OP_W(OP_W)) bus ();

    serial_adder_host #(
        .OP_W       (OP_W),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] all_outs();
        return {bus.busy, bus.done, bus.result, bus.mismatch, bus.timeout_err,
                bus.ser_en_o, bus.ser_a_o, bus.ser_b_o};
    endfunction

    // Called at the negedge where rst_n is released; start may be held high.
    task automatic do_flush();
        logic busy_dropped;
        logic stray;
        busy_dropped = 1'b0;
        stray        = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (!bus.busy) busy_dropped = 1'b1;
            stray |= bus.ser_en_o | bus.ser_a_o | bus.ser_b_o | bus.done | bus.timeout_err;
        end
        tick();
        chk("flush_busy_held", 32'(busy_dropped), 0);
        chk("flush_no_activity", 32'(stray), 0);
        chk("flush_end_idle", 32'(bus.busy), 0);
        $display("flush: busy held for %0d edges, now idle", TIMEOUT - 1);
    endtask

    // Entered at a negedge with the host in IDLE; returns after the GAP edge.
    task automatic run_txn(input int idx, input vec_t v);
        logic [OP_W-1:0]  ra;
        logic [OP_W-1:0]  rb;
        logic [OP_W-1:0]  en_seen;
        logic [RES_W-1:0] rres;
        logic             leak;
        logic             early;
        ra = '0; rb = '0; en_seen = '0; leak = 1'b0; early = 1'b0;

        bus.start = 1'b1;
        bus.op_a  = v.a;
        bus.op_b  = v.b;
        tick();                                   // edge S
        if (!v.keep_start) bus.start = 1'b0;
        chk("send_busy", 32'(bus.busy), 1);

        // Responder view of the link: one bit per edge, MSB first.
        for (int i = OP_W - 1; i >= 0; i--) begin
            en_seen[i] = bus.ser_en_o;
            ra[i]      = bus.ser_a_o;
            rb[i]      = bus.ser_b_o;
            tick();
        end                                       // now after edge S+OP_W
        chk("link_en_pattern", 32'(en_seen), 32'(1 << (OP_W - 1)));
        chk("link_op_a", 32'(ra), 32'(v.a));
        chk("link_op_b", 32'(rb), 32'(v.b));
        chk("wait_link_quiet", 32'({bus.ser_en_o, bus.ser_a_o, bus.ser_b_o}), 0);

        rres = RES_W'(ra) + RES_W'(rb);
        if (v.mode == 2) rres[0] = ~rres[0];

        if (v.mode == 1) begin
            for (int k = 1; k < TIMEOUT; k++) begin
                tick();
                early |= bus.timeout_err | bus.done;
                leak  |= bus.ser_en_o;
            end
            tick();                               // TIMEOUT-th edge in WAIT
            chk("timeout_pulse", 32'(bus.timeout_err), 1);
            chk("timeout_not_early", 32'(early), 0);
            chk("timeout_no_done", 32'(bus.done), 0);
            chk("timeout_result_kept", 32'(bus.result), 32'(v.exp_result));
            chk("timeout_mismatch", 32'(bus.mismatch), 32'(v.exp_mismatch));
            chk("timeout_link_quiet", 32'(leak), 0);
            tick();
            chk("timeout_width", 32'(bus.timeout_err), 0);
            chk("timeout_gap_idle", 32'(bus.busy), 0);
        end else begin
            tick();                               // S+3
            early |= bus.done;
            leak  |= bus.ser_en_o;
            bus.ser_en_i  = 1'b1;
            bus.ser_out_i = rres[RES_W-1];
            tick();                               // S+4: MSB captured
            bus.ser_en_i = 1'b0;
            for (int j = RES_W - 2; j >= 0; j--) begin
                early |= bus.done;
                leak  |= bus.ser_en_o;
                bus.ser_out_i = rres[j];
                tick();
            end                                   // S+6: last capture
            bus.ser_out_i = 1'b1;
            bus.ser_en_i  = v.spur;
            leak |= bus.ser_en_o;
            chk("done_pulse", 32'(bus.done), 1);
            chk("done_not_early", 32'(early), 0);
            chk("no_en_during_reply", 32'(leak), 0);
            chk("result", 32'(bus.result), 32'(v.exp_result));
            chk("mismatch", 32'(bus.mismatch), 32'(v.exp_mismatch));
            chk("busy_at_done", 32'(bus.busy), 1);
            chk("no_timeout", 32'(bus.timeout_err), 0);
            tick();                               // S+7: GAP edge
            bus.ser_en_i = 1'b0;
            chk("done_width", 32'(bus.done), 0);
            chk("gap_to_idle", 32'(bus.busy), 0);
            chk("result_held", 32'(bus.result), 32'(v.exp_result));
        end
        $display("txn %0d a=%0d b=%0d mode=%0d result=%b mismatch=%b",
                 idx, v.a, v.b, v.mode, bus.result, bus.mismatch);
    endtask

    initial begin
        vec_t v;
        logic moved;
        checks = 0;
        errors = 0;

        vecs[0] = '{2'd3, 2'd3, 0, 1'b0, 1'b0, 3'b110, 1'b0};
        vecs[1] = '{2'd2, 2'd1, 0, 1'b1, 1'b0, 3'b011, 1'b0};
        vecs[2] = '{2'd0, 2'd0, 0, 1'b0, 1'b1, 3'b000, 1'b0};
        vecs[3] = '{2'd1, 2'd1, 2, 1'b0, 1'b0, 3'b011, 1'b1};
        vecs[4] = '{2'd1, 2'd2, 1, 1'b0, 1'b0, 3'b011, 1'b0};
        vecs[5] = '{2'd3, 2'd2, 0, 1'b0, 1'b0, 3'b101, 1'b0};
        vecs[6] = '{2'd2, 2'd2, 0, 1'b0, 1'b0, 3'b100, 1'b0};

        // Start held high through reset and FLUSH: must only be taken in IDLE.
        rst_n         = 1'b0;
        bus.start     = 1'b1;
        bus.op_a      = 2'd3;
        bus.op_b      = 2'd3;
        bus.ser_en_i  = 1'b0;
        bus.ser_out_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 0);
        rst_n = 1'b1;
        do_flush();

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Reset in the middle of RECV.
        bus.start = 1'b1; bus.op_a = 2'd2; bus.op_b = 2'd2;
        tick();                                   // S
        bus.start = 1'b0;
        tick(); tick(); tick();                   // S+1..S+3
        bus.ser_en_i = 1'b1; bus.ser_out_i = 1'b1;
        tick();                                   // S+4
        bus.ser_en_i = 1'b0; bus.ser_out_i = 1'b0;
        tick();                                   // S+5, still receiving
        chk("recv_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(all_outs()), 0);
        @(negedge clk);
        bus.ser_out_i = 1'b1;
        bus.start = 1'b1; bus.op_a = 2'd1; bus.op_b = 2'd2;
        rst_n = 1'b1;
        do_flush();
        v = '{2'd1, 2'd2, 0, 1'b0, 1'b0, 3'b011, 1'b0};
        run_txn(7, v);

        // Spurious enable while IDLE.
        bus.start = 1'b0;
        bus.ser_en_i = 1'b1; bus.ser_out_i = 1'b0;
        moved = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            moved |= bus.busy | bus.done | bus.timeout_err | bus.ser_en_o;
        end
        bus.ser_en_i = 1'b0; bus.ser_out_i = 1'b1;
        chk("idle_spurious_ignored", 32'(moved), 0);
        chk("idle_spurious_result", 32'(bus.result), 32'(3'b011));
        $display("idle spurious enable: busy=%b result=%b", bus.busy, bus.result);

        v = '{2'd3, 2'd1, 0, 1'b0, 1'b0, 3'b100, 1'b0};
        run_txn(8, v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
